mult_datapath: RTL and testbench

//   Shift-add multiplier datapath driven by the multiplier control FSM.

---
 rtl/mult_datapath.sv | 60 ++++++
 tb/tb_mult_datapath.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: operand shift registers, 2*WIDTH accumulator and
// bit counter, sequenced by the external multiplier control FSM.
module mult_datapath #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic               load_rst,
   input  logic               shift_inc,
   input  logic               acc,
   output logic               lsb_B,
   output logic               out_comp,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

   logic [2*WIDTH-1:0] reg_a;
   logic [WIDTH-1:0]   reg_b;
   logic [2*WIDTH-1:0] accum;
   logic [CNT_W-1:0]   count;
   logic               done;
   logic               shift_en;

   assign done     = (count == CNT_DONE);
   // Once every bit is consumed, further shift strobes must not disturb the result.
   assign shift_en = shift_inc && !done;

   // Accumulate always sees the pre-shift reg_a, so acc and shift_inc may coincide.
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_a <= '0;
         reg_b <= '0;
         accum <= '0;
         count <= '0;
      end else if (load_rst) begin
         reg_a <= {{WIDTH{1'b0}}, op_a};
         reg_b <= op_b;
         accum <= '0;
         count <= '0;
      end else begin
         if (acc) begin
            accum <= accum + reg_a;
         end
         if (shift_en) begin
            reg_a <= reg_a << 1;
            reg_b <= reg_b >> 1;
            count <= count + 1'b1;
         end
      end
   end

   assign lsb_B    = reg_b[0];
   assign out_comp = done;
   assign product  = accum;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath at WIDTH=8, with a small behavioural stand-in for
// the control FSM (load, then test/add/shift per bit).
module tb_mult_datapath;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic           load_rst;
   logic           shift_inc;
   logic           acc;
   logic           lsb_B;
   logic           out_comp;
   logic [2*W-1:0] product;

   int n_vec = 0;
   int n_err = 0;

   mult_datapath #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .op_a      (op_a),
      .op_b      (op_b),
      .load_rst  (load_rst),
      .shift_inc (shift_inc),
      .acc       (acc),
      .lsb_B     (lsb_B),
      .out_comp  (out_comp),
      .product   (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Starts and ends at a falling edge; strobes are cleared after the rising edge.
   task automatic step(input logic l, input logic s, input logic a);
      load_rst  = l;
      shift_inc = s;
      acc       = a;
      @(posedge clk);
      @(negedge clk);
      load_rst  = 1'b0;
      shift_inc = 1'b0;
      acc       = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
      op_a = a;
      op_b = b;
      step(1'b1, 1'b0, 1'b0);
      // Operands are free to change after the load cycle.
      op_a = W'($urandom_range(0, 255));
      op_b = W'($urandom_range(0, 255));
   endtask

   // Control FSM model: test, optional add, shift; stops when out_comp is seen.
   task automatic run_ctrl(output int cycles, output int n_acc);
      logic b;
      cycles = 0;
      n_acc  = 0;
      while (!out_comp && cycles < 100) begin
         b = lsb_B;
         step(1'b0, 1'b0, 1'b0);
         cycles++;
         if (b) begin
            step(1'b0, 1'b0, 1'b1);
            cycles++;
            n_acc++;
         end
         step(1'b0, 1'b1, 1'b0);
         cycles++;
      end
   endtask

   initial begin
      int cyc;
      int nacc;
      reset     = 1'b0;
      op_a      = '0;
      op_b      = '0;
      load_rst  = 1'b0;
      shift_inc = 1'b0;
      acc       = 1'b0;
      @(negedge clk);

      // Reset state, then hold with no strobes
      do_reset();
      check("rst_product", product, 0);
      check("rst_lsb", lsb_B, 0);
      check("rst_comp", out_comp, 0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      check("idle_product", product, 0);
      check("idle_comp", out_comp, 0);

      // 13 * 11
      load(8'd13, 8'd11);
      check("ld_lsb_11", lsb_B, 1);
      check("ld_product", product, 0);
      run_ctrl(cyc, nacc);
      check("p_13x11", product, 143);
      check("cyc_13x11", cyc, 19);
      check("acc_13x11", nacc, 3);

      // Saturated counter: shift strobes ignored, reg_a still 13<<8
      repeat (5) step(1'b0, 1'b1, 1'b0);
      check("hold_product", product, 143);
      check("hold_comp", out_comp, 1);
      check("hold_lsb", lsb_B, 0);
      step(1'b0, 1'b0, 1'b1);
      check("hold_rega", product, 143 + 3328);

      // 255 * 255
      load(8'd255, 8'd255);
      run_ctrl(cyc, nacc);
      check("p_255x255", product, 65025);
      check("cyc_255x255", cyc, 24);

      // 200 * 0
      load(8'd200, 8'd0);
      check("ld_lsb_0", lsb_B, 0);
      run_ctrl(cyc, nacc);
      check("p_x0", product, 0);
      check("cyc_x0", cyc, 16);
      check("acc_x0", nacc, 0);

      // Reset mid-run
      load(8'd7, 8'd5);
      step(1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b1, 1'b0);
      check("mid_partial", product, 7);
      do_reset();
      check("mid_rst_product", product, 0);
      check("mid_rst_lsb", lsb_B, 0);
      check("mid_rst_comp", out_comp, 0);

      // load_rst wins over acc
      op_a = 8'd3;
      op_b = 8'd4;
      step(1'b1, 1'b0, 1'b1);
      check("ldacc_product", product, 0);
      check("ldacc_lsb", lsb_B, 0);
      run_ctrl(cyc, nacc);
      check("p_3x4", product, 12);
      check("cyc_3x4", cyc, 17);

      // Simultaneous acc and shift_inc
      load(8'd3, 8'd5);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      check("both_pre", product, 9);
      check("both_pre_lsb", lsb_B, 0);
      step(1'b0, 1'b1, 1'b1);
      check("both_accum", product, 15);
      check("both_lsb", lsb_B, 1);
      step(1'b0, 1'b0, 1'b1);
      check("both_rega", product, 27);
      repeat (5) step(1'b0, 1'b1, 1'b0);
      check("both_cnt7", out_comp, 0);
      step(1'b0, 1'b1, 1'b0);
      check("both_cnt8", out_comp, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
